// File: rtl/per_stream_in.sv
// Peripheral-bus input stream: host pushes 16-bit words into a FIFO and the CPU pops them
// through DATA, polls STAT and controls flush/underflow-clear/interrupt-enable through CTRL.
module per_stream_in #(
  parameter logic [14:0] BASE_ADDR = 15'h0110,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AW        = 3
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        irq
);

  localparam logic [13:0] BASE_W  = BASE_ADDR[14:1];
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count, count_nxt;
  logic          undf, ie, ie_nxt;

  logic sel_data, sel_stat, sel_ctrl, rd, ctrl_wr;
  logic flush_wr, uclr_wr, data_rd, pop, push, underflow;
  logic ne, full;
  logic unused_din;

  // Register decode and access qualification
  assign sel_data  = per_en && (per_addr == BASE_W);
  assign sel_stat  = per_en && (per_addr == BASE_W + 14'd1);
  assign sel_ctrl  = per_en && (per_addr == BASE_W + 14'd2);
  assign rd        = per_en && (per_we == 2'b00);
  assign ctrl_wr   = sel_ctrl && per_we[0];
  assign flush_wr  = ctrl_wr && per_din[0];
  assign uclr_wr   = ctrl_wr && per_din[1];
  assign data_rd   = sel_data && rd;
  assign unused_din = ^per_din[15:3];

  assign ne        = (count != '0);
  assign full      = (count == DEPTH_C);
  assign pop       = data_rd && ne;
  assign underflow = data_rd && !ne;
  assign in_ready  = !full && !flush_wr;
  assign push      = in_valid && in_ready;

  assign count_nxt = flush_wr ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
  assign ie_nxt    = ctrl_wr ? per_din[2] : ie;

  // Combinational read mux; zero whenever nothing is selected for read
  always_comb begin
    per_dout = 16'h0000;
    if (rd) begin
      if (sel_data && ne) per_dout = mem[rp];
      else if (sel_stat)  per_dout = {8'(count), 5'b00000, undf, full, ne};
      else if (sel_ctrl)  per_dout = {13'd0, ie, 2'b00};
    end
  end

  // Pointers, occupancy, sticky underflow and the post-edge interrupt level
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      undf  <= 1'b0;
      ie    <= 1'b0;
      irq   <= 1'b0;
    end else begin
      count <= count_nxt;
      ie    <= ie_nxt;
      irq   <= ie_nxt && (count_nxt != '0);
      if (flush_wr) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push) wp <= wp + AW'(1);
        if (pop)  rp <= rp + AW'(1);
      end
      if (underflow)    undf <= 1'b1;
      else if (uclr_wr) undf <= 1'b0;
    end
  end

  // Storage needs no reset; stale words are never visible past count
  always_ff @(posedge mclk) begin
    if (push) mem[wp] <= in_data;
  end

endmodule

// File: tb/tb_per_stream_in.sv
// Bench for per_stream_in: directed scenarios checked against spec constants plus a
// randomized run checked against a queue-based reference model.
module tb_per_stream_in;

  localparam int DEPTH = 8;
  localparam logic [13:0] BASE_W = 14'h0088;
  localparam logic [13:0] A_DATA = BASE_W;
  localparam logic [13:0] A_STAT = BASE_W + 14'd1;
  localparam logic [13:0] A_CTRL = BASE_W + 14'd2;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = '0;
  logic [15:0] per_dout;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [15:0] a_dout, e_dout;
  logic        a_rdy, e_rdy, a_irq, e_irq;

  logic [15:0] q[$];
  logic        m_undf, m_ie;

  per_stream_in #(.BASE_ADDR(15'h0110), .DEPTH(8), .AW(3)) dut (
    .mclk(mclk), .reset_n(reset_n), .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_we(per_we), .per_dout(per_dout), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .irq(irq)
  );

  always #5 mclk = ~mclk;

  // Reference model: one bus access plus one host offer per cycle, applied to a word queue
  task automatic model_step(input logic en, input logic [13:0] addr, input logic [1:0] we,
                            input logic [15:0] din, input logic v, input logic [15:0] d);
    int k;
    logic rd, flush;
    k = int'(addr) - int'(BASE_W);
    rd = en && (we == 2'b00);
    flush = en && (k == 2) && we[0] && din[0];
    e_rdy = (q.size() < DEPTH) && !flush;
    e_dout = 16'h0000;
    if (rd) begin
      case (k)
        0: e_dout = (q.size() > 0) ? q[0] : 16'h0000;
        1: e_dout = {8'(q.size()), 5'd0, m_undf, q.size() == DEPTH, q.size() != 0};
        2: e_dout = {13'd0, m_ie, 2'b00};
        default: e_dout = 16'h0000;
      endcase
    end
    if (rd && k == 0) begin
      if (q.size() > 0) void'(q.pop_front());
      else m_undf = 1'b1;
    end
    if (v && e_rdy) q.push_back(d);
    if (en && k == 2 && we[0]) begin
      if (din[0]) q.delete();
      if (din[1]) m_undf = 1'b0;
      m_ie = din[2];
    end
    e_irq = m_ie && (q.size() != 0);
  endtask

  // One clock: drive at negedge, sample combinational outputs, then irq after the edge
  task automatic step(input logic en, input logic [13:0] addr, input logic [1:0] we,
                      input logic [15:0] din, input logic v, input logic [15:0] d);
    @(negedge mclk);
    per_en = en; per_addr = addr; per_we = we; per_din = din;
    in_valid = v; in_data = d;
    #1;
    a_dout = per_dout;
    a_rdy = in_ready;
    model_step(en, addr, we, din, v, d);
    @(posedge mclk);
    #1;
    a_irq = irq;
  endtask

  task automatic rd(input logic [13:0] addr);
    step(1'b1, addr, 2'b00, 16'h0000, 1'b0, 16'h0000);
  endtask

  task automatic wr(input logic [13:0] addr, input logic [15:0] din);
    step(1'b1, addr, 2'b01, din, 1'b0, 16'h0000);
  endtask

  task automatic push(input logic [15:0] d);
    step(1'b0, 14'h0000, 2'b00, 16'h0000, 1'b1, d);
  endtask

  // Asserts reset away from the edge and samples outputs while it is held low
  task automatic do_reset();
    @(negedge mclk);
    per_en = 1'b0; per_we = 2'b00; per_din = '0; in_valid = 1'b0; in_data = '0;
    #2;
    reset_n = 1'b0;
    #1;
    a_dout = per_dout; a_rdy = in_ready; a_irq = irq;
    q.delete(); m_undf = 1'b0; m_ie = 1'b0;
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", a_rdy); end
    checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", a_irq); end
    rd(A_STAT);
    checks++; if (a_dout !== 16'h0000) begin errors++; $display("FAIL reset_stat: got %h expected 0000", a_dout); end
  endtask

  task automatic test_basic();
    logic [15:0] exp_w [3];
    exp_w = '{16'h1234, 16'hABCD, 16'h0007};
    for (int i = 0; i < 3; i++) push(exp_w[i]);
    rd(A_STAT);
    checks++; if (a_dout !== 16'h0301) begin errors++; $display("FAIL basic_stat: got %h expected 0301", a_dout); end
    for (int i = 0; i < 3; i++) begin
      rd(A_DATA);
      checks++; if (a_dout !== exp_w[i]) begin errors++; $display("FAIL basic_data%0d: got %h expected %h", i, a_dout, exp_w[i]); end
    end
    rd(A_STAT);
    checks++; if (a_dout !== 16'h0000) begin errors++; $display("FAIL basic_stat_empty: got %h expected 0000", a_dout); end
  endtask

  task automatic test_full_wrap();
    for (int i = 1; i <= 8; i++) push(16'(i));
    rd(A_STAT);
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", a_rdy); end
    checks++; if (a_dout !== 16'h0803) begin errors++; $display("FAIL full_stat: got %h expected 0803", a_dout); end
    step(1'b1, A_DATA, 2'b00, 16'h0000, 1'b1, 16'h0009);
    checks++; if (a_dout !== 16'h0001) begin errors++; $display("FAIL full_pop: got %h expected 0001", a_dout); end
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %b expected 0", a_rdy); end
    push(16'h0009);
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL full_ready_rise: got %b expected 1", a_rdy); end
    rd(A_STAT);
    checks++; if (a_dout !== 16'h0803) begin errors++; $display("FAIL full_stat2: got %h expected 0803", a_dout); end
    for (int i = 2; i <= 9; i++) begin
      rd(A_DATA);
      checks++; if (a_dout !== 16'(i)) begin errors++; $display("FAIL wrap_data%0d: got %h expected %h", i, a_dout, 16'(i)); end
    end
    rd(A_STAT);
    checks++; if (a_dout !== 16'h0000) begin errors++; $display("FAIL wrap_stat_empty: got %h expected 0000", a_dout); end
  endtask

  task automatic test_underflow();
    rd(A_DATA);
    checks++; if (a_dout !== 16'h0000) begin errors++; $display("FAIL undf_data: got %h expected 0000", a_dout); end
    rd(A_STAT);
    checks++; if (a_dout !== 16'h0004) begin errors++; $display("FAIL undf_stat: got %h expected 0004", a_dout); end
    wr(A_CTRL, 16'h0002);
    rd(A_STAT);
    checks++; if (a_dout !== 16'h0000) begin errors++; $display("FAIL undf_clear: got %h expected 0000", a_dout); end
    // Push and underflow read in one cycle: no bypass, word still stored
    step(1'b1, A_DATA, 2'b00, 16'h0000, 1'b1, 16'h5A5A);
    checks++; if (a_dout !== 16'h0000) begin errors++; $display("FAIL nobypass_data: got %h expected 0000", a_dout); end
    rd(A_STAT);
    checks++; if (a_dout !== 16'h0105) begin errors++; $display("FAIL nobypass_stat: got %h expected 0105", a_dout); end
    rd(A_DATA);
    checks++; if (a_dout !== 16'h5A5A) begin errors++; $display("FAIL nobypass_word: got %h expected 5a5a", a_dout); end
    wr(A_CTRL, 16'h0002);
  endtask

  task automatic test_irq();
    wr(A_CTRL, 16'h0004);
    checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL irq_ie_only: got %b expected 0", a_irq); end
    rd(A_CTRL);
    checks++; if (a_dout !== 16'h0004) begin errors++; $display("FAIL irq_ctrl_read: got %h expected 0004", a_dout); end
    push(16'hBEEF);
    checks++; if (a_irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", a_irq); end
    rd(A_DATA);
    checks++; if (a_dout !== 16'hBEEF) begin errors++; $display("FAIL irq_pop: got %h expected beef", a_dout); end
    checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b expected 0", a_irq); end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 5; i++) push(16'(16'h0100 + i));
    step(1'b1, A_CTRL, 2'b01, 16'h0001, 1'b1, 16'h7777);
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", a_rdy); end
    step(1'b1, A_STAT, 2'b00, 16'h0000, 1'b0, 16'h0000);
    checks++; if (a_dout !== 16'h0000) begin errors++; $display("FAIL flush_stat: got %h expected 0000", a_dout); end
    push(16'h1111);
    push(16'h2222);
    wr(A_CTRL, 16'h0004);
    checks++; if (a_irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b expected 1", a_irq); end
    do_reset();
    checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", a_irq); end
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", a_rdy); end
    checks++; if (a_dout !== 16'h0000) begin errors++; $display("FAIL midreset_dout: got %h expected 0000", a_dout); end
    rd(A_STAT);
    checks++; if (a_dout !== 16'h0000) begin errors++; $display("FAIL postreset_stat: got %h expected 0000", a_dout); end
    rd(A_CTRL);
    checks++; if (a_dout !== 16'h0000) begin errors++; $display("FAIL postreset_ie: got %h expected 0000", a_dout); end
  endtask

  task automatic test_random();
    logic        en, v, hold;
    logic [13:0] addr;
    logic [1:0]  we;
    logic [15:0] din, d;
    hold = 1'b0; v = 1'b0; d = '0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 1) == 0);
      addr = BASE_W + 14'($urandom_range(0, 3));
      we   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      din  = 16'($urandom);
      if ($urandom_range(0, 7) != 0) din[0] = 1'b0;
      if (!hold) begin
        v = ($urandom_range(0, 99) < ((i % 200) < 100 ? 80 : 15));
        d = 16'($urandom);
      end
      step(en, addr, we, din, v, d);
      hold = v && !a_rdy;
      checks++; if (a_dout !== e_dout) begin errors++; $display("FAIL rand_dout cyc %0d: got %h expected %h", i, a_dout, e_dout); end
      checks++; if (a_rdy !== e_rdy) begin errors++; $display("FAIL rand_ready cyc %0d: got %b expected %b", i, a_rdy, e_rdy); end
      checks++; if (a_irq !== e_irq) begin errors++; $display("FAIL rand_irq cyc %0d: got %b expected %b", i, a_irq, e_irq); end
    end
  endtask

  initial begin
    m_undf = 1'b0;
    m_ie = 1'b0;
    test_reset();
    test_basic();
    test_full_wrap();
    test_underflow();
    test_irq();
    test_flush_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
